mac_pipe_n: RTL and testbench
=============================

# mac_pipe_n

Parametrised, pipelined signed multiply-accumulate unit, successor to the single-stage MAC in the Project datapath. A configurable number of multiplier pipeline stages carry the product together with its control sideband, so `init_acc` and `input_valid` stay aligned with the data they qualify. A built-in length counter pulses `out_valid` when a dot product of `acc_len` terms completes. Optional saturating accumulation is available. The block sits between the operand fetch logic and the result writeback of the dot-product engine.

## Interface
- `INW`, default 16: signed operand and `init_value` width.
- `OUTW`, default 64: signed accumulator/output width. Legal range: `2*INW <= OUTW <= 128`.
- `PIPES`, default 2: number of product register stages. Legal range: 1..4.
- `CNTW`, default 16: width of `acc_len` and the internal term counter.
- `clk`, input, 1: clock. All state updates on its rising edge.
- `reset`, input, 1: reset, synchronous, active-high.
- `input0`, `input1`, input, INW: signed operands.
- `init_value`, input, INW: signed accumulator preload value, sign-extended to OUTW.
- `init_acc`, input, 1: restart accumulation at this input cycle.
- `input_valid`, input, 1: `input0`/`input1` carry a valid term.
- `acc_len`, input, CNTW: unsigned number of terms per result. Sampled on every edge; hold it stable during a dot product. 0 disables `out_valid`.
- `out`, output, OUTW: signed accumulator value.
- `out_valid`, output, 1: one-cycle pulse; `out` holds a completed result.
- `sat_flag`, output, 1: sticky saturation indicator.

## Operation
- **Product:** `input0*input1` is a full `2*INW`-bit signed product; no truncation. The product is sign-extended to OUTW only at the accumulator adder.
- **Pipeline:** stage 0 registers the product, `init_acc`, `input_valid` and `init_value`. Stages 1..PIPES-1 forward all four unchanged. The head stage drives the accumulator. The pipeline never stalls.
- **Accumulator update, from head-stage signals (priority order):**
  - init=1, valid=1: `out <= sext(init_value) + sext(product)`; count <= 1.
  - init=1, valid=0: `out <= sext(init_value)`; count <= 0.
  - init=0, valid=1: `out <= out + sext(product)`; count <= count+1.
  - init=0, valid=0: hold `out` and count.
- **Completion:** when an update leaves count == `acc_len` (with `acc_len != 0`), `out_valid` is 1 for the following cycle and count resets to 0. `out` is not cleared; accumulation continues until the next `init_acc`.
- **Counter limit:** the counter saturates at `2^CNTW-1` and does not wrap.
- **Overflow:** behaviour is set by the Configuration section.
- **Reset:** all stage registers, `out`, count, `out_valid` and `sat_flag` are cleared to 0. In-flight terms are discarded. Reset asserted mid-dot-product yields no `out_valid`.

## Timing
- Inputs sampled at edge k are reflected in `out` after edge k+PIPES. Example: PIPES=1 gives `out` after edge k+1.
- `out_valid` goes high after the same edge that writes the final term, and lasts exactly one cycle.
- Throughput: one term per cycle, sustained. Back-to-back dot products are allowed: `init_acc` may be asserted on the cycle right after the last term of the previous result.
- First valid input can be sampled on the first edge with `reset=0`. `out` first changes PIPES edges later.

## Configuration
- **`MAC_SAT_EN` defined:**
  - An accumulation that exceeds the signed OUTW range clamps `out` to `2^(OUTW-1)-1` (positive overflow) or `-2^(OUTW-1)` (negative overflow).
  - `sat_flag` is set and stays set until `init_acc` reaches the head stage or `reset` is asserted.
- **`MAC_SAT_EN` undefined:** addition wraps modulo `2^OUTW`, and `sat_flag` is tied to 0.

## Test plan
- **Basic dot product:** PIPES=2, `acc_len`=3. Init cycle with `init_value`=5, valid=0. Then terms (2,3), (-4,6), (7,7). Required: `out` = 5, 11, -13, 36 on successive head cycles, and `out_valid`=1 exactly once, alongside `out`=36.
- **Simultaneous init and valid:** `init_acc`=1, `input_valid`=1, `init_value`=-1, operands (3,4). Required: `out`=11 and count=1 after edge k+PIPES.
- **Gapped input:** valid pattern 1,0,0,1 with operands (1,1) and `acc_len`=2. Required: `out` holds through the gap, and `out_valid` fires only after the 4th term's head edge.
- **Extreme operands:** INW=16, both operands -32768. Required: product +2^30, added without wrap at OUTW=64.
- **Overflow:** OUTW=32, init 0, terms (-32768,-32768) ×3. Required:
  - With `MAC_SAT_EN`: `out`=2147483647 and `sat_flag`=1.
  - Without `MAC_SAT_EN`: `out`=-1073741824 and `sat_flag`=0.
- **Reset mid-stream:** `reset` asserted while 2 terms are in flight. Required: next cycle `out`=0, `out_valid`=0, `sat_flag`=0, and no stale term accumulates after reset is released.

Source files
------------

// File: rtl/mac_pipe_n.sv
// Pipelined signed multiply-accumulate with a dot-product length counter.
// Define MAC_SAT_EN to clamp the accumulator on overflow and drive sat_flag; otherwise it wraps.
module mac_pipe_n #(
    parameter int INW   = 16,
    parameter int OUTW  = 64,
    parameter int PIPES = 2,
    parameter int CNTW  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic signed [INW-1:0]  input0,
    input  logic signed [INW-1:0]  input1,
    input  logic signed [INW-1:0]  init_value,
    input  logic                   init_acc,
    input  logic                   input_valid,
    input  logic [CNTW-1:0]        acc_len,
    output logic signed [OUTW-1:0] out,
    output logic                   out_valid,
    output logic                   sat_flag
);

    localparam int PW = 2 * INW;

    logic signed [PW-1:0]  prod_p [PIPES];
    logic signed [INW-1:0] ival_p [PIPES];
    logic                  init_p [PIPES];
    logic                  vld_p  [PIPES];

    logic signed [PW-1:0]  prod_p0_next;
    logic signed [PW-1:0]  prod_h;
    logic signed [INW-1:0] ival_h;
    logic                  init_h;
    logic                  vld_h;

    logic signed [OUTW-1:0] acc_base;
    logic signed [OUTW-1:0] addend;
    logic signed [OUTW-1:0] acc_next;
    logic [CNTW-1:0]        cnt;
    logic [CNTW-1:0]        cnt_next;
    logic                   done;

    function automatic logic [CNTW-1:0] cnt_inc(input logic [CNTW-1:0] c);
        return (c == {CNTW{1'b1}}) ? c : c + CNTW'(1);
    endfunction

`ifdef MAC_SAT_EN
    logic signed [OUTW:0] sum_w;
    logic                 sum_ovf;
    logic                 sat_r;

    function automatic logic signed [OUTW:0] add_wide(input logic signed [OUTW-1:0] a,
                                                      input logic signed [OUTW-1:0] b);
        return (OUTW+1)'(a) + (OUTW+1)'(b);
    endfunction

    function automatic logic ovf_of(input logic signed [OUTW:0] s);
        return s[OUTW] ^ s[OUTW-1];
    endfunction

    // The extra MSB holds the true sign, so it picks the clamp direction.
    function automatic logic signed [OUTW-1:0] saturate(input logic signed [OUTW:0] s);
        if (!ovf_of(s))
            return s[OUTW-1:0];
        else if (s[OUTW])
            return {1'b1, {(OUTW-1){1'b0}}};
        else
            return {1'b0, {(OUTW-1){1'b1}}};
    endfunction
`endif

    // Full-precision product; both operands are widened before multiplying.
    assign prod_p0_next = PW'(input0) * PW'(input1);

    // ---- stage 0 .. PIPES-1: product and sideband travel together ----
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < PIPES; s++) begin
                prod_p[s] <= '0;
                ival_p[s] <= '0;
                init_p[s] <= 1'b0;
                vld_p[s]  <= 1'b0;
            end
        end else begin
            prod_p[0] <= prod_p0_next;
            ival_p[0] <= init_value;
            init_p[0] <= init_acc;
            vld_p[0]  <= input_valid;
            for (int s = 1; s < PIPES; s++) begin
                prod_p[s] <= prod_p[s-1];
                ival_p[s] <= ival_p[s-1];
                init_p[s] <= init_p[s-1];
                vld_p[s]  <= vld_p[s-1];
            end
        end
    end

    assign prod_h = prod_p[PIPES-1];
    assign ival_h = ival_p[PIPES-1];
    assign init_h = init_p[PIPES-1];
    assign vld_h  = vld_p[PIPES-1];

    // ---- head stage: accumulate and count terms ----
    always_comb begin
        acc_base = init_h ? OUTW'(ival_h) : out;
        addend   = vld_h ? OUTW'(prod_h) : '0;
`ifdef MAC_SAT_EN
        sum_w    = add_wide(acc_base, addend);
        sum_ovf  = ovf_of(sum_w);
        acc_next = saturate(sum_w);
`else
        acc_next = acc_base + addend;
`endif
        if (init_h)
            cnt_next = {{(CNTW-1){1'b0}}, vld_h};
        else if (vld_h)
            cnt_next = cnt_inc(cnt);
        else
            cnt_next = cnt;
        done = (init_h || vld_h) && (acc_len != '0) && (cnt_next == acc_len);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= done;
            if (init_h || vld_h) begin
                out <= acc_next;
                cnt <= done ? '0 : cnt_next;
            end
        end
    end

`ifdef MAC_SAT_EN
    // Sticky until a restart reaches the head; a restart that itself overflows re-arms it.
    always_ff @(posedge clk) begin
        if (reset)
            sat_r <= 1'b0;
        else if (init_h)
            sat_r <= vld_h & sum_ovf;
        else if (vld_h && sum_ovf)
            sat_r <= 1'b1;
    end

    assign sat_flag = sat_r;
`else
    assign sat_flag = 1'b0;
`endif

endmodule

// File: tb/tb_mac_pipe_n.sv
// Self-checking bench for mac_pipe_n: two instances (64-bit/2-stage and 32-bit/3-stage)
// share one input stream and are compared every cycle against a latency-shifted arithmetic model.
module tb_mac_pipe_n;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               reset = 1'b1;
    logic signed [15:0] in0 = '0, in1 = '0, iv = '0;
    logic               init = 1'b0, vld = 1'b0;
    logic [15:0]        len = '0;

    logic signed [63:0] out_a;
    logic signed [31:0] out_b;
    logic               ov_a, ov_b, sf_a, sf_b;

    int checks = 0;
    int failures = 0;

`ifdef MAC_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    mac_pipe_n #(.INW(16), .OUTW(64), .PIPES(2), .CNTW(16)) dut_a (
        .clk(clk), .reset(reset), .input0(in0), .input1(in1), .init_value(iv),
        .init_acc(init), .input_valid(vld), .acc_len(len),
        .out(out_a), .out_valid(ov_a), .sat_flag(sf_a));

    mac_pipe_n #(.INW(16), .OUTW(32), .PIPES(3), .CNTW(16)) dut_b (
        .clk(clk), .reset(reset), .input0(in0), .input1(in1), .init_value(iv),
        .init_acc(init), .input_valid(vld), .acc_len(len),
        .out(out_b), .out_valid(ov_b), .sat_flag(sf_b));

    task automatic chk(input string name, input logic signed [127:0] got,
                       input logic signed [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    localparam int NE = 8192;
    bit                 rec_rst  [NE];
    bit                 rec_init [NE];
    bit                 rec_vld  [NE];
    logic signed [15:0] rec_a    [NE];
    logic signed [15:0] rec_b    [NE];
    logic signed [15:0] rec_iv   [NE];
    logic [15:0]        rec_len  [NE];
    int                 ecount = 0;

    logic signed [127:0] m_acc [2];
    int                  m_cnt [2];
    bit                  m_ov  [2];
    bit                  m_sat [2];
    bit                  live = 1'b0;

    // Inputs of edge t-P land in the accumulator at edge t unless a reset hit any edge in between.
    task automatic model_step(input int d, input int t);
        int p, w, e;
        bit ok, ovf;
        logic signed [127:0] v, mx, mn;
        p = (d == 0) ? 2 : 3;
        w = (d == 0) ? 64 : 32;
        m_ov[d] = 1'b0;
        if (rec_rst[t]) begin
            m_acc[d] = '0; m_cnt[d] = 0; m_sat[d] = 1'b0;
            return;
        end
        e = t - p;
        if (e < 0) return;
        ok = 1'b1;
        for (int i = e; i < t; i++) if (rec_rst[i]) ok = 1'b0;
        if (!ok || !(rec_init[e] || rec_vld[e])) return;
        v = rec_init[e] ? 128'(rec_iv[e]) : m_acc[d];
        if (rec_vld[e]) v = v + 128'(rec_a[e]) * 128'(rec_b[e]);
        mx = (128'sd1 <<< (w - 1)) - 128'sd1;
        mn = -mx - 128'sd1;
        ovf = (v > mx) || (v < mn);
        if (SAT) begin
            if (v > mx) v = mx;
            else if (v < mn) v = mn;
            if (rec_init[e]) m_sat[d] = ovf;
            else if (ovf) m_sat[d] = 1'b1;
        end else begin
            v = (v <<< (128 - w)) >>> (128 - w);
            m_sat[d] = 1'b0;
        end
        m_acc[d] = v;
        if (rec_init[e]) m_cnt[d] = rec_vld[e] ? 1 : 0;
        else if (rec_vld[e]) m_cnt[d] = (m_cnt[d] == 65535) ? 65535 : m_cnt[d] + 1;
        if (rec_len[t] != 0 && m_cnt[d] == int'(rec_len[t])) begin
            m_ov[d] = 1'b1;
            m_cnt[d] = 0;
        end
    endtask

    always @(posedge clk) begin
        if (ecount < NE) begin
            rec_rst[ecount]  = reset;
            rec_init[ecount] = init;
            rec_vld[ecount]  = vld;
            rec_a[ecount]    = in0;
            rec_b[ecount]    = in1;
            rec_iv[ecount]   = iv;
            rec_len[ecount]  = len;
            model_step(0, ecount);
            model_step(1, ecount);
            if (reset) live = 1'b1;
            ecount++;
        end
    end

    // Per-cycle comparison of both instances against the model.
    always @(posedge clk) begin
        #1;
        if (live && ecount < NE) begin
            chk("out_a", out_a, m_acc[0]);
            chk("ov_a", ov_a, m_ov[0]);
            chk("sat_a", sf_a, m_sat[0]);
            chk("out_b", out_b, m_acc[1]);
            chk("ov_b", ov_b, m_ov[1]);
            chk("sat_b", sf_b, m_sat[1]);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit i_init, input bit i_vld, input int i_iv,
                         input int a, input int b);
        init = i_init;
        vld  = i_vld;
        iv   = 16'(i_iv);
        in0  = 16'(a);
        in1  = 16'(b);
        tick();
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0);
    endtask

    initial begin
        reset = 1'b1;
        repeat (3) tick();
        chk("rst_out_a", out_a, 0);
        chk("rst_ov_a", ov_a, 0);
        chk("rst_sat_b", sf_b, 0);
        reset = 1'b0;
        idle();

        // basic dot product: 5, 11, -13, 36
        len = 16'd3;
        drive(1, 0, 5, 0, 0);
        drive(0, 1, 0, 2, 3);
        drive(0, 1, 0, -4, 6);
        chk("basic_0", out_a, 5);
        drive(0, 1, 0, 7, 7);
        chk("basic_1", out_a, 11);
        idle();
        chk("basic_2", out_a, -13);
        chk("basic_2_ov", ov_a, 0);
        idle();
        chk("basic_3", out_a, 36);
        chk("basic_3_ov", ov_a, 1);
        chk("model_pin", m_acc[0], 36);
        idle();
        chk("basic_pulse_end", ov_a, 0);
        chk("basic_hold", out_a, 36);

        // simultaneous init and valid
        len = 16'd1;
        drive(1, 1, -1, 3, 4);
        idle();
        idle();
        chk("initvld_out", out_a, 11);
        chk("initvld_ov", ov_a, 1);

        // gapped input
        len = 16'd2;
        drive(1, 1, 0, 1, 1);
        idle();
        idle();
        chk("gap_0", out_a, 1);
        chk("gap_0_ov", ov_a, 0);
        drive(0, 1, 0, 1, 1);
        chk("gap_1", out_a, 1);
        idle();
        chk("gap_2", out_a, 1);
        chk("gap_2_ov", ov_a, 0);
        idle();
        chk("gap_3", out_a, 2);
        chk("gap_3_ov", ov_a, 1);

        // extreme operands, also the 32-bit overflow case on dut_b
        len = 16'd0;
        drive(1, 0, 0, 0, 0);
        drive(0, 1, 0, -32768, -32768);
        drive(0, 1, 0, -32768, -32768);
        drive(0, 1, 0, -32768, -32768);
        chk("ext_1", out_a, 128'sd1073741824);
        idle();
        chk("ext_2", out_a, 128'sd2147483648);
        idle();
        chk("ext_3", out_a, 128'sd3221225472);
        idle();
        chk("ovf_out_b", out_b, SAT ? 128'sd2147483647 : -128'sd1073741824);
        chk("ovf_sat_b", sf_b, SAT ? 1 : 0);

        // reset with two terms in flight
        drive(1, 1, 0, 5, 5);
        drive(0, 1, 0, 6, 6);
        reset = 1'b1;
        idle();
        chk("rst_mid_out_a", out_a, 0);
        chk("rst_mid_ov_a", ov_a, 0);
        chk("rst_mid_out_b", out_b, 0);
        chk("rst_mid_sat_b", sf_b, 0);
        reset = 1'b0;
        repeat (4) idle();
        chk("rst_stale_a", out_a, 0);
        chk("rst_stale_b", out_b, 0);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 299) == 0);
            init  = ($urandom_range(0, 7) == 0);
            vld   = ($urandom_range(0, 3) != 0);
            if (init) len = 16'($urandom_range(0, 5));
            iv = 16'($urandom);
            if ($urandom_range(0, 15) == 0) begin
                in0 = $urandom_range(0, 1) ? 16'sh8000 : 16'sh7fff;
                in1 = $urandom_range(0, 1) ? 16'sh8000 : 16'sh7fff;
            end else begin
                in0 = 16'($urandom);
                in1 = 16'($urandom);
            end
            tick();
        end
        reset = 1'b0;
        repeat (5) idle();
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
